// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter in front of a single-ported data
//               memory; one access every two cycles, range-checked, with a
//               registered read response. Define DMEM_ARB_FIXED_PRIO_EN to
//               give port 0 fixed priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic              p0_err,
    output logic              p1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic              c_S_IDLE   = 1'b0;
    localparam logic              c_S_ACCESS = 1'b1;
    localparam logic [ADDR_W-1:0] c_DEPTH    = ADDR_W'(MEM_DEPTH);

    logic              r_state;
    logic              r_owner;
    logic [DATA_W-1:0] r_rdata;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic              r_p0_err;
    logic              r_p1_err;

    logic              w_access;
    logic              w_any_req;
    logic              w_winner;
    logic              w_owner_we;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_owner_addr;

    assign w_access     = (r_state == c_S_ACCESS);
    assign w_any_req    = p0_req | p1_req;
    assign w_owner_we   = r_owner ? p1_we   : p0_we;
    assign w_owner_addr = r_owner ? p1_addr : p0_addr;
    assign w_in_range   = (w_owner_addr < c_DEPTH);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_winner = ~p0_req;
`else
    logic r_last_owner;

    // On contention the port that did not win last time takes the slot.
    assign w_winner = (p0_req & p1_req) ? ~r_last_owner : p1_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_owner <= 1'b1;
        end else if (!w_access && w_any_req) begin
            r_last_owner <= w_winner;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_S_IDLE;
            r_owner     <= 1'b0;
            r_rdata     <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_err    <= 1'b0;
            r_p1_err    <= 1'b0;
        end else begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_err    <= 1'b0;
            r_p1_err    <= 1'b0;
            if (r_state == c_S_IDLE) begin
                if (w_any_req) begin
                    r_owner <= w_winner;
                    r_state <= c_S_ACCESS;
                end
            end else begin
                r_state <= c_S_IDLE;
                // Writes only report errors; rdata is left untouched by them.
                if (!w_owner_we) begin
                    r_rdata     <= w_in_range ? mem_rdata : '0;
                    r_p0_rvalid <= ~r_owner;
                    r_p1_rvalid <= r_owner;
                end
                r_p0_err <= ~r_owner & ~w_in_range;
                r_p1_err <=  r_owner & ~w_in_range;
            end
        end
    end

    // Enables decode from state, so an asynchronous reset drops them at once.
    assign p0_gnt    = w_access & ~r_owner;
    assign p1_gnt    = w_access &  r_owner;
    assign mem_write = w_access &  w_owner_we & w_in_range;
    assign mem_read  = w_access & ~w_owner_we & w_in_range;
    assign mem_addr  = w_owner_addr;
    assign mem_wdata = r_owner ? p1_wdata : p0_wdata;

    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_err    = r_p0_err;
    assign p1_err    = r_p1_err;
    assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural memory
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        int          port;
        bit          is_read;
        bit          err;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       sb[$];
    resp_t       mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        exp_p0v, exp_p1v, exp_p0e, exp_p1e;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(64)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_err(p0_err), .p1_err(p1_err), .rdata(rdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Low address bits only, so a stray enable on an out-of-range address aliases onto word 0.
    always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[5:0]];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
    end

    // Response scoreboard: every rvalid/err pulse must match the head entry.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && (p0_rvalid || p1_rvalid || p0_err || p1_err)) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_resp: p0_rvalid=%b p1_rvalid=%b p0_err=%b p1_err=%b, required no response",
                             p0_rvalid, p1_rvalid, p0_err, p1_err);
                end else begin
                    mon_e   = sb.pop_front();
                    exp_p0v = (mon_e.port == 0) && mon_e.is_read;
                    exp_p1v = (mon_e.port == 1) && mon_e.is_read;
                    exp_p0e = (mon_e.port == 0) && mon_e.err;
                    exp_p1e = (mon_e.port == 1) && mon_e.err;
                    if (p0_rvalid !== exp_p0v || p1_rvalid !== exp_p1v || p0_err !== exp_p0e ||
                        p1_err !== exp_p1e || cyc != mon_e.due || (mon_e.is_read && rdata !== mon_e.data)) begin
                        bad++;
                        $display("FAIL resp: got v=%b%b e=%b%b rdata=%h cyc=%0d, required v=%b%b e=%b%b rdata=%h cyc=%0d",
                                 p0_rvalid, p1_rvalid, p0_err, p1_err, rdata, cyc,
                                 exp_p0v, exp_p1v, exp_p0e, exp_p1e, mon_e.data, mon_e.due);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic drop(input int port);
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    // Called in the grant cycle: the response is due one cycle later.
    task automatic expect_resp(input int port, input bit is_read, input bit err, input logic [31:0] data);
        resp_t e;
        e.port = port; e.is_read = is_read; e.err = err; e.data = data; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read} !== 8'h00 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL por_outputs: flags=%b rdata=%h, required 00000000 rdata=0",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read}, rdata);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        drive(0, 1'b0, 32'd7, 32'h0);
        tick();
        expect_resp(0, 1'b1, 1'b0, ref_mem[7]);
        drop(0);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        total++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read} !== 8'h00 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL idle_reset: flags=%b rdata=%h, required 00000000 rdata=0",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_write, mem_read}, rdata);
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL reset_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 32'd5, 32'hDEADBEEF);
        total++;
        if (p0_gnt !== 1'b0) begin bad++; $display("FAIL wr_early_gnt: got %b, required 0", p0_gnt); end
        tick();
        total++;
        if ({p0_gnt, p1_gnt, mem_write, mem_read} !== 4'b1010 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_access: gnt/we/re=%b addr=%0d wdata=%h, required 1010 addr=5 wdata=deadbeef",
                     {p0_gnt, p1_gnt, mem_write, mem_read}, mem_addr, mem_wdata);
        end
        ref_mem[5] = 32'hDEADBEEF;
        drop(0);
        tick();
        drive(0, 1'b0, 32'd5, 32'h0);
        tick();
        total++;
        if ({p0_gnt, mem_write, mem_read} !== 3'b101 || mem_addr !== 32'd5) begin
            bad++;
            $display("FAIL rd_access: gnt/we/re=%b addr=%0d, required 101 addr=5", {p0_gnt, mem_write, mem_read}, mem_addr);
        end
        expect_resp(0, 1'b1, 1'b0, ref_mem[5]);
        drop(0);
        tick(); tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL wr_rd_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_round_robin();
        int exp_port [4];
        int grants;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_port = '{0, 0, 0, 0};
`else
        exp_port = '{0, 1, 0, 1};
`endif
        reset = 1'b0;
        tick();
        drive(0, 1'b0, 32'd1, 32'h0);
        drive(1, 1'b0, 32'd2, 32'h0);
        reset = 1'b1;
        grants = 0;
        for (int c = 0; c < 20 && grants < 4; c++) begin
            tick();
            if (p0_gnt || p1_gnt) begin
                total++;
                if (p0_gnt === p1_gnt || p1_gnt !== (exp_port[grants] == 1)) begin
                    bad++;
                    $display("FAIL rr_grant%0d: p0_gnt=%b p1_gnt=%b, required port %0d", grants, p0_gnt, p1_gnt, exp_port[grants]);
                end
                expect_resp(exp_port[grants], 1'b1, 1'b0, ref_mem[exp_port[grants] == 1 ? 2 : 1]);
                grants++;
            end
        end
        total++;
        if (grants != 4) begin bad++; $display("FAIL rr_timeout: got %0d grants, required 4", grants); end
        drop(0); drop(1);
        tick(); tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rr_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_out_of_range();
        drive(1, 1'b0, 32'd64, 32'h0);
        tick();
        total++;
        if ({p0_gnt, p1_gnt, mem_write, mem_read} !== 4'b0100) begin
            bad++;
            $display("FAIL oor_rd_access: gnt/we/re=%b, required 0100", {p0_gnt, p1_gnt, mem_write, mem_read});
        end
        expect_resp(1, 1'b1, 1'b1, 32'h0);
        drop(1);
        tick();
        drive(1, 1'b1, 32'd64, 32'hFFFF_FFFF);
        tick();
        total++;
        if ({p0_gnt, p1_gnt, mem_write, mem_read} !== 4'b0100) begin
            bad++;
            $display("FAIL oor_wr_access: gnt/we/re=%b, required 0100", {p0_gnt, p1_gnt, mem_write, mem_read});
        end
        expect_resp(1, 1'b0, 1'b1, 32'h0);
        drop(1);
        tick(); tick();
        drive(0, 1'b0, 32'd0, 32'h0);
        tick();
        expect_resp(0, 1'b1, 1'b0, ref_mem[0]);
        drop(0);
        tick(); tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL oor_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_cross_port();
        drive(1, 1'b1, 32'd63, 32'h1234_5678);
        tick();
        total++;
        if ({p1_gnt, mem_write} !== 2'b11 || mem_addr !== 32'd63) begin
            bad++;
            $display("FAIL xp_wr_access: gnt/we=%b addr=%0d, required 11 addr=63", {p1_gnt, mem_write}, mem_addr);
        end
        ref_mem[63] = 32'h1234_5678;
        drop(1);
        tick();
        drive(0, 1'b0, 32'd63, 32'h0);
        tick();
        expect_resp(0, 1'b1, 1'b0, ref_mem[63]);
        drop(0);
        tick(); tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL xp_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_during_access();
        drive(0, 1'b1, 32'd10, 32'hAAAA_5555);
        tick();
        total++;
        if (mem_write !== 1'b1) begin bad++; $display("FAIL rda_we_before: got %b, required 1", mem_write); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (mem_write !== 1'b0 || p0_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rda_async: mem_write=%b p0_gnt=%b, required 0 0", mem_write, p0_gnt);
        end
        drop(0);
        tick();
        reset = 1'b1;
        tick(); tick();
        drive(0, 1'b0, 32'd10, 32'h0);
        tick();
        expect_resp(0, 1'b1, 1'b0, ref_mem[10]);
        drop(0);
        tick(); tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rda_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_dropped_req();
        drive(1, 1'b0, 32'd3, 32'h0);
        tick();
        total++;
        if (p1_gnt !== 1'b1) begin bad++; $display("FAIL drop_p1_gnt: got %b, required 1", p1_gnt); end
        expect_resp(1, 1'b1, 1'b0, ref_mem[3]);
        drop(1);
        drive(0, 1'b0, 32'd4, 32'h0);
        tick();
        drop(0);
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (p0_gnt !== 1'b0) begin bad++; $display("FAIL drop_p0_gnt%0d: got %b, required 0", c, p0_gnt); end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL drop_pending: got %0d, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_cross_port();
        test_reset_during_access();
        test_dropped_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
